led_bank: RTL and testbench

- Parametrised successor to the 8-LED bus peripheral: NUM_LEDS outputs behind the same 4-way handshaking data bus (Write/Read/Ack).
- Adds a small register map, optional interrupt-display source, hardware blink, global PWM dimming and write-1-to-toggle.
- Sits on the SoC peripheral bus beside the UART/GPIO blocks; LED pins go straight to the board.

---
 rtl/led_bank_pkg.sv | 18 +
 rtl/led_blink_timer.sv | 34 +++
 rtl/led_bank.sv | 110 +++++++++++
 tb/tb_led_bank.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_bank_pkg.sv
// led_bank_pkg: shared constants for the LED bank peripheral.
// Register addresses, CTRL bit positions and bus width.
package led_bank_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 3;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_DATA   = 3'd1;
  localparam logic [2:0] ADDR_BLINK  = 3'd2;
  localparam logic [2:0] ADDR_DUTY   = 3'd3;
  localparam logic [2:0] ADDR_TOGGLE = 3'd4;

  localparam int CTRL_IRQ   = 0;
  localparam int CTRL_BLINK = 1;
  localparam int CTRL_PWM   = 2;

endpackage

// File: rtl/led_blink_timer.sv
// led_blink_timer: prescaler plus phase flop for hardware blink.
// Phase flips every `period` clocks while enabled, else sits at 1.
module led_blink_timer #(
  parameter int BLINK_BITS = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [BLINK_BITS-1:0] period,
  input  logic                  restart,
  output logic                  phase
);

  logic [BLINK_BITS-1:0] cnt;
  logic                  hold;
  logic                  wrap;

  assign hold = restart | ~enable | (period == '0);
  assign wrap = (cnt == period - BLINK_BITS'(1));

  // count half-period clocks; flip phase on each wrap
  always_ff @(posedge clock) begin
    if (reset || hold) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (wrap) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + BLINK_BITS'(1);
    end
  end

endmodule

// File: rtl/led_bank.sv
// led_bank: parametrised LED bank on the Write/Read/Ack bus.
// Register file, blink, PWM dimming and write-1-to-toggle.
module led_bank
  import led_bank_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int PWM_BITS   = 4,
  parameter int BLINK_BITS = 24
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          Address,
  input  logic [DATA_W-1:0]   dataIn,
  input  logic [NUM_LEDS-1:0] IP,
  input  logic                Write,
  input  logic                Read,
  output logic [DATA_W-1:0]   dataOut,
  output logic                Ack,
  output logic [NUM_LEDS-1:0] LED
);

  logic                  ack_q;
  logic [CTRL_W-1:0]     ctrl;
  logic [NUM_LEDS-1:0]   data;
  logic [NUM_LEDS-1:0]   src;
  logic [BLINK_BITS-1:0] period;
  logic [PWM_BITS-1:0]   duty;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic                  commit;
  logic                  blink_chg;
  logic                  restart;
  logic                  phase;
  logic                  pwm_on;
  logic                  unused_bits;

  assign Ack       = ack_q;
  assign commit    = Write & ~ack_q;
  assign blink_chg = dataIn[CTRL_BLINK] ^ ctrl[CTRL_BLINK];
  assign restart   = commit
                   & ((Address == ADDR_BLINK)
                   | ((Address == ADDR_CTRL) & blink_chg));
  assign src       = ctrl[CTRL_IRQ] ? IP : data;
  assign pwm_on    = ~ctrl[CTRL_PWM]
                   | (&duty)
                   | (pwm_cnt < duty);

  // only the low bits of dataIn land in registers
  assign unused_bits = ^dataIn;

  // acknowledge follows the request one cycle later
  always_ff @(posedge clock) begin
    if (reset) ack_q <= 1'b0;
    else       ack_q <= Write | Read;
  end

  // register writes, once per transaction
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl   <= '0;
      data   <= '0;
      period <= '0;
      duty   <= '0;
    end else if (commit) begin
      unique case (Address)
        ADDR_CTRL:   ctrl   <= dataIn[CTRL_W-1:0];
        ADDR_DATA:   data   <= dataIn[NUM_LEDS-1:0];
        ADDR_BLINK:  period <= dataIn[BLINK_BITS-1:0];
        ADDR_DUTY:   duty   <= dataIn[PWM_BITS-1:0];
        ADDR_TOGGLE: data   <= data ^ dataIn[NUM_LEDS-1:0];
        default: ;
      endcase
    end
  end

  // free-running PWM ramp
  always_ff @(posedge clock) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  // gated LED drive
  always_ff @(posedge clock) begin
    if (reset) LED <= '0;
    else       LED <= src & {NUM_LEDS{phase & pwm_on}};
  end

  // read mux, zero-extended
  always_comb begin
    dataOut = '0;
    unique case (Address)
      ADDR_CTRL:  dataOut = DATA_W'(ctrl);
      ADDR_DATA:  dataOut = DATA_W'(data);
      ADDR_BLINK: dataOut = DATA_W'(period);
      ADDR_DUTY:  dataOut = DATA_W'(duty);
      default:    dataOut = '0;
    endcase
  end

  led_blink_timer #(
    .BLINK_BITS(BLINK_BITS)
  ) u_blink (
    .clock  (clock),
    .reset  (reset),
    .enable (ctrl[CTRL_BLINK]),
    .period (period),
    .restart(restart),
    .phase  (phase)
  );

endmodule

// File: tb/tb_led_bank.sv
// tb_led_bank: directed plus random checks of led_bank
// against a cycle-indexed reference model.
module tb_led_bank;

  localparam int N  = 8;
  localparam int PB = 4;
  localparam int BB = 24;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    Address;
  logic [31:0]   dataIn;
  logic [N-1:0]  IP;
  logic          Write;
  logic          Read;
  logic [31:0]   dataOut;
  logic          Ack;
  logic [N-1:0]  LED;

  int vectors;
  int miscompares;

  logic [2:0]    m_ctrl;
  logic [N-1:0]  m_data;
  logic [N-1:0]  m_led;
  logic [BB-1:0] m_period;
  logic [PB-1:0] m_duty;
  logic          m_ack;
  int unsigned   cyc;
  int unsigned   bstart;

  led_bank #(
    .NUM_LEDS  (N),
    .PWM_BITS  (PB),
    .BLINK_BITS(BB)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .Address(Address),
    .dataIn (dataIn),
    .IP     (IP),
    .Write  (Write),
    .Read   (Read),
    .dataOut(dataOut),
    .Ack    (Ack),
    .LED    (LED)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // blink phase from elapsed clocks since the timer (re)started
  function automatic logic m_phase();
    int unsigned p;
    if (!(m_ctrl[1] && m_period != '0)) return 1'b1;
    p = 32'(m_period);
    return (((cyc - bstart) / p) % 2) == 0;
  endfunction

  // PWM ramp value is simply clocks since reset, modulo 2^PB
  function automatic logic m_pwm();
    int ramp;
    ramp = int'(cyc % (1 << PB));
    if (!m_ctrl[2]) return 1'b1;
    if (m_duty == '1) return 1'b1;
    return ramp < int'(m_duty);
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_ctrl);
      3'd1:    return 32'(m_data);
      3'd2:    return 32'(m_period);
      3'd3:    return 32'(m_duty);
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    logic [N-1:0] src;
    logic         commit;
    logic         restart;
    logic         act;
    if (reset) begin
      m_ctrl   = '0;
      m_data   = '0;
      m_period = '0;
      m_duty   = '0;
      m_ack    = 1'b0;
      m_led    = '0;
      cyc      = 0;
      bstart   = 0;
    end else begin
      src     = m_ctrl[0] ? IP : m_data;
      commit  = Write && !m_ack;
      restart = commit && (Address == 3'd2 ||
                (Address == 3'd0 && dataIn[1] != m_ctrl[1]));
      act     = m_ctrl[1] && m_period != '0;
      m_led   = (m_phase() && m_pwm()) ? src : '0;
      if (commit) begin
        case (Address)
          3'd0: m_ctrl   = dataIn[2:0];
          3'd1: m_data   = dataIn[N-1:0];
          3'd2: m_period = dataIn[BB-1:0];
          3'd3: m_duty   = dataIn[PB-1:0];
          3'd4: m_data   = m_data ^ dataIn[N-1:0];
          default: ;
        endcase
      end
      m_ack = Write || Read;
      cyc++;
      if (restart || !act) bstart = cyc;
    end
    @(posedge clock);
    #1;
    chk("led", 32'(LED), 32'(m_led));
    chk("ack", 32'(Ack), 32'(m_ack));
    chk("dout", dataOut, m_rd(Address));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    Address = a;
    dataIn  = v;
    Write   = 1'b1;
    tick();
    chk("wr_ack", 32'(Ack), 32'd1);
    dataIn = $urandom;
    tick();
    Write = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    Address = a;
    Read    = 1'b1;
    tick();
    chk("rd", dataOut, exp);
    Read = 1'b0;
    tick();
  endtask

  initial begin
    int ons;
    vectors     = 0;
    miscompares = 0;
    m_ctrl = '0; m_data = '0; m_period = '0;
    m_duty = '0; m_ack = 1'b0; m_led = '0;
    cyc = 0; bstart = 0;
    reset = 1'b1; Write = 1'b0; Read = 1'b0;
    Address = '0; dataIn = '0; IP = '0;
    tick();
    tick();
    chk("rst_led", 32'(LED), 32'd0);
    chk("rst_ack", 32'(Ack), 32'd0);
    reset = 1'b0;
    tick();

    // DATA write held three cycles, data changes mid-hold
    Address = 3'd1; dataIn = 32'hA5; Write = 1'b1;
    tick();
    chk("a5_ack", 32'(Ack), 32'd1);
    dataIn = 32'h12;
    tick();
    chk("a5_led", 32'(LED), 32'hA5);
    tick();
    Write = 1'b0;
    tick();
    chk("a5_ackdrop", 32'(Ack), 32'd0);
    rd(3'd1, 32'h0000_00A5);

    // interrupt source
    IP = 8'h3C;
    wr(3'd0, 32'h1);
    chk("ip_3c", 32'(LED), 32'h3C);
    IP = 8'h81;
    tick();
    chk("ip_81", 32'(LED), 32'h81);
    rd(3'd0, 32'h1);

    // blink
    wr(3'd1, 32'hFF);
    wr(3'd2, 32'd4);
    wr(3'd0, 32'h2);
    ons = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (LED == 8'hFF) ons++;
    end
    chk("blink_on", 32'(ons), 32'd8);
    wr(3'd2, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("blink_off_ff", 32'(LED), 32'hFF);
    end

    // PWM dimming
    wr(3'd1, 32'h01);
    wr(3'd0, 32'h4);
    wr(3'd3, 32'd4);
    ons = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (LED[0]) ons++;
    end
    chk("pwm_4", 32'(ons), 32'd4);
    wr(3'd3, 32'd0);
    ons = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (LED[0]) ons++;
    end
    chk("pwm_0", 32'(ons), 32'd0);
    wr(3'd3, 32'd15);
    ons = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (LED[0]) ons++;
    end
    chk("pwm_15", 32'(ons), 32'd16);

    // toggle and unmapped address
    wr(3'd0, 32'h0);
    wr(3'd1, 32'h0F);
    wr(3'd4, 32'hFF);
    rd(3'd1, 32'hF0);
    rd(3'd4, 32'h0);
    wr(3'd6, $urandom);
    rd(3'd0, 32'h0);
    rd(3'd1, 32'hF0);
    rd(3'd2, 32'h0);
    rd(3'd3, 32'd15);

    // reset during blink + PWM with Ack high
    wr(3'd1, 32'hFF);
    wr(3'd2, 32'd3);
    wr(3'd3, 32'd7);
    wr(3'd0, 32'h6);
    Address = 3'd1; dataIn = 32'h55; Write = 1'b1;
    tick();
    chk("mid_ack", 32'(Ack), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_led", 32'(LED), 32'd0);
    chk("mid_ack0", 32'(Ack), 32'd0);
    reset = 1'b0;
    Write = 1'b0;
    tick();
    rd(3'd0, 32'h0);
    rd(3'd1, 32'h0);
    rd(3'd3, 32'h0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      Write   = ($urandom_range(0, 3) == 0);
      Read    = ($urandom_range(0, 1) == 0);
      Address = 3'($urandom_range(0, 7));
      dataIn  = (Address == 3'd2) ? $urandom_range(0, 6)
                                  : $urandom;
      IP      = N'($urandom);
      tick();
    end
    reset = 1'b0;
    Write = 1'b0;
    Read  = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
